// File: rtl/pair_pkg.sv
// Shared definitions for the {num_worthless, useful} operand-reduction pair.
// Field widths are passed at call sites so one set of helpers serves every instance.
package pair_pkg;

    localparam int PAIR_N     = 16;
    localparam int PAIR_M     = 3;
    localparam int PAIR_W     = PAIR_N + PAIR_M + 1;
    localparam int PAIR_MAX_W = 64;

    typedef logic [PAIR_MAX_W-1:0] pair_word_t;

    function automatic pair_word_t field_mask(input int n);
        return (pair_word_t'(1) << n) - pair_word_t'(1);
    endfunction

    // The count field sits above the n-bit useful field.
    function automatic pair_word_t pack_pair(input pair_word_t num_worthless,
                                             input pair_word_t useful,
                                             input int         n);
        return (num_worthless << n) | (useful & field_mask(n));
    endfunction

    function automatic pair_word_t unpack_num_worthless(input pair_word_t pair, input int n);
        return pair >> n;
    endfunction

    function automatic pair_word_t unpack_useful(input pair_word_t pair, input int n);
        return pair & field_mask(n);
    endfunction

endpackage

// File: rtl/pair_fifo_ptr.sv
// Read/write pointer pair with a wrap bit; derives full, empty and level.
// flush clears both pointers and wins over any concurrent push or pop.
module pair_fifo_ptr
    import pair_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    input  logic          out_ready,
    output logic          in_ready,
    output logic          out_valid,
    output logic          wr_en,
    output logic [AW-1:0] wr_idx,
    output logic [AW-1:0] rd_idx,
    output logic [LW-1:0] level
);

    logic [LW-1:0] wr_ptr;
    logic [LW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign wr_en     = push && !flush;

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];
    assign level  = wr_ptr - rd_ptr;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + LW'(1);
            if (pop)  rd_ptr <= rd_ptr + LW'(1);
        end
    end

endmodule

// File: rtl/pair_fifo.sv
// First-word-fall-through elastic buffer between the leading-one detector and the
// truncated multiplier; holds the pair storage and gates the head outputs when empty.
module pair_fifo
    import pair_pkg::*;
#(
    parameter  int N     = PAIR_N,
    parameter  int M     = PAIR_M,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1,
    localparam int NW    = M + 1,
    localparam int W     = N + M + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [NW-1:0] num_worthless_in,
    input  logic [N-1:0]  useful_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [NW-1:0] num_worthless_out,
    output logic [N-1:0]  useful_out,
    output logic [LW-1:0] level
);

    logic [W-1:0]  mem [DEPTH];
    logic [W-1:0]  head;
    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;

    pair_fifo_ptr #(.DEPTH(DEPTH)) u_ptr (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .rd_idx    (rd_idx),
        .level     (level)
    );

    // NOTE: storage is deliberately not reset; the empty pointers plus output gating hide stale data.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= W'(pack_pair(pair_word_t'(num_worthless_in),
                                        pair_word_t'(useful_in), N));
        end
    end

    assign head = mem[rd_idx];

    assign num_worthless_out = out_valid ? NW'(unpack_num_worthless(pair_word_t'(head), N)) : '0;
    assign useful_out        = out_valid ? N'(unpack_useful(pair_word_t'(head), N))         : '0;

endmodule
